// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush/bubble sequencing for the five-stage pipeline buffers,
//            plus the interrupt entry FSM (enabled by PIPE_HAZARD_CTRL_INT_EN).
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int INT_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_int,
  input  logic [2:0] i_dec_Rsrc1,
  input  logic [2:0] i_dec_Rsrc2,
  input  logic       i_dec_use1,
  input  logic       i_dec_use2,
  input  logic       i_ex_mem_read,
  input  logic [2:0] i_ex_Rdst,
  input  logic       i_branch_taken,
  input  logic       i_mem_busy,
  output logic       o_pc_en,
  output logic       o_fd_en,
  output logic       o_da_en,
  output logic       o_am_en,
  output logic       o_mw_en,
  output logic       o_fd_bubble,
  output logic       o_da_bubble,
  output logic       o_int_inject,
  output logic [1:0] o_int_step,
  output logic       o_int_vec,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_PUSH  = 2'd2,
    S_VEC   = 2'd3
  } state_t;

  localparam logic [2:0] C_DRAIN_LAST = 3'(DRAIN_CYCLES - 1);
  localparam logic [2:0] C_PUSH_LAST  = 3'(INT_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_pending, w_pending_nxt;
  logic       r_int_low;
  logic       w_int_rise, w_int_req, w_load_use;
  logic       w_pc_en, w_fd_en, w_da_en, w_am_en, w_mw_en;
  logic       w_fd_bubble, w_da_bubble, w_inject, w_vec;

  // r_int_low resets to 0, so a level held high through reset is not an edge
`ifdef PIPE_HAZARD_CTRL_INT_EN
  assign w_int_rise = i_int & r_int_low;
`else
  assign w_int_rise = 1'b0;
`endif

  assign w_int_req  = r_pending | w_int_rise;
  assign w_load_use = i_ex_mem_read &&
                      ((i_dec_use1 && (i_dec_Rsrc1 == i_ex_Rdst)) ||
                       (i_dec_use2 && (i_dec_Rsrc2 == i_ex_Rdst)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_RUN;
      r_cnt     <= 3'd0;
      r_pending <= 1'b0;
      r_int_low <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
      r_int_low <= ~i_int;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending | w_int_rise;
    w_pc_en       = 1'b1;
    w_fd_en       = 1'b1;
    w_da_en       = 1'b1;
    w_am_en       = 1'b1;
    w_mw_en       = 1'b1;
    w_fd_bubble   = 1'b0;
    w_da_bubble   = 1'b0;
    w_inject      = (r_state == S_PUSH);
    w_vec         = (r_state == S_VEC);
    if (i_mem_busy) begin
      w_pc_en = 1'b0;
      w_fd_en = 1'b0;
      w_da_en = 1'b0;
      w_am_en = 1'b0;
      w_mw_en = 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_branch_taken) begin
            w_fd_bubble = 1'b1;
            w_da_bubble = 1'b1;
          end else if (w_int_req) begin
            w_state_nxt   = S_DRAIN;
            w_cnt_nxt     = 3'd0;
            w_pending_nxt = 1'b0;
          end else if (w_load_use) begin
            w_pc_en     = 1'b0;
            w_fd_en     = 1'b0;
            w_da_bubble = 1'b1;
          end
        end
        S_DRAIN: begin
          w_fd_bubble = 1'b1;
          // Branch target becomes the saved PC, so draining starts over
          if (i_branch_taken) begin
            w_da_bubble = 1'b1;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_pc_en = 1'b0;
            if (r_cnt == C_DRAIN_LAST) begin
              w_state_nxt = S_PUSH;
              w_cnt_nxt   = 3'd0;
            end else begin
              w_cnt_nxt = r_cnt + 3'd1;
            end
          end
        end
        S_PUSH: begin
          w_pc_en = 1'b0;
          if (r_cnt == C_PUSH_LAST) begin
            w_state_nxt = S_VEC;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
        S_VEC: begin
          w_fd_bubble = 1'b1;
          w_state_nxt = S_RUN;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  assign o_pc_en     = rst & w_pc_en;
  assign o_fd_en     = rst & w_fd_en;
  assign o_da_en     = rst & w_da_en;
  assign o_am_en     = rst & w_am_en;
  assign o_mw_en     = rst & w_mw_en;
  assign o_fd_bubble = ~rst | w_fd_bubble;
  assign o_da_bubble = ~rst | w_da_bubble;

`ifdef PIPE_HAZARD_CTRL_INT_EN
  assign o_int_inject = rst & w_inject;
  assign o_int_step   = (rst && w_inject) ? r_cnt[1:0] : 2'd0;
  assign o_int_vec    = rst & w_vec;
  assign o_busy       = rst & (r_state != S_RUN);
`else
  logic w_unused;
  assign w_unused     = ^{r_int_low, w_inject, w_vec, r_cnt};
  assign o_int_inject = 1'b0;
  assign o_int_step   = 2'd0;
  assign o_int_vec    = 1'b0;
  assign o_busy       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic, each
// cycle compared against a sequence-position reference model.
module tb_pipe_hazard_ctrl;

  localparam int D = 3;
  localparam int I = 2;
`ifdef PIPE_HAZARD_CTRL_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_int = 1'b0;
  logic [2:0] i_dec_Rsrc1 = '0, i_dec_Rsrc2 = '0, i_ex_Rdst = '0;
  logic       i_dec_use1 = 1'b0, i_dec_use2 = 1'b0, i_ex_mem_read = 1'b0;
  logic       i_branch_taken = 1'b0, i_mem_busy = 1'b0;
  logic       o_pc_en, o_fd_en, o_da_en, o_am_en, o_mw_en;
  logic       o_fd_bubble, o_da_bubble, o_int_inject, o_int_vec, o_busy;
  logic [1:0] o_int_step;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: m_seq is -1 when idle, else position within the entry
  // sequence (0..D-1 drain, D..D+I-1 push, D+I vector).
  int m_seq  = -1;
  bit m_pend = 1'b0;
  bit m_last = 1'b1;
  bit last_vec;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(D), .INT_CYCLES(I)) dut (
    .clk(clk), .rst(rst), .i_int(i_int),
    .i_dec_Rsrc1(i_dec_Rsrc1), .i_dec_Rsrc2(i_dec_Rsrc2),
    .i_dec_use1(i_dec_use1), .i_dec_use2(i_dec_use2),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_Rdst(i_ex_Rdst),
    .i_branch_taken(i_branch_taken), .i_mem_busy(i_mem_busy),
    .o_pc_en(o_pc_en), .o_fd_en(o_fd_en), .o_da_en(o_da_en),
    .o_am_en(o_am_en), .o_mw_en(o_mw_en),
    .o_fd_bubble(o_fd_bubble), .o_da_bubble(o_da_bubble),
    .o_int_inject(o_int_inject), .o_int_step(o_int_step),
    .o_int_vec(o_int_vec), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] model_out();
    logic pc, fd, da, am, mw, fb, db, inj, vec, bsy;
    logic [1:0] st;
    bit rise, lu;
    if (!rst) return 12'b00000_11_0_00_0_0;
    pc = 1; fd = 1; da = 1; am = 1; mw = 1; fb = 0; db = 0; inj = 0; st = 0; vec = 0;
    rise = INT_EN && i_int && !m_last;
    lu = i_ex_mem_read && ((i_dec_use1 && i_dec_Rsrc1 == i_ex_Rdst) ||
                           (i_dec_use2 && i_dec_Rsrc2 == i_ex_Rdst));
    bsy = (m_seq >= 0);
    if (m_seq >= D && m_seq < D + I) begin inj = 1; st = 2'(m_seq - D); end
    if (m_seq == D + I) vec = 1;
    if (i_mem_busy) begin
      pc = 0; fd = 0; da = 0; am = 0; mw = 0;
    end else if (m_seq < 0) begin
      if (i_branch_taken) begin fb = 1; db = 1; end
      else if (!(m_pend || rise) && lu) begin pc = 0; fd = 0; db = 1; end
    end else if (m_seq < D) begin
      fb = 1;
      if (i_branch_taken) db = 1; else pc = 0;
    end else if (m_seq < D + I) begin
      pc = 0;
    end else begin
      fb = 1;
    end
    return {pc, fd, da, am, mw, fb, db, inj, st, vec, bsy};
  endfunction

  task automatic model_step();
    bit rise;
    if (!rst) begin m_seq = -1; m_pend = 0; m_last = 1; return; end
    rise = INT_EN && i_int && !m_last;
    m_last = i_int;
    if (i_mem_busy) m_pend = m_pend | rise;
    else if (m_seq < 0) begin
      if (!i_branch_taken && (m_pend || rise)) begin m_seq = 0; m_pend = 0; end
      else m_pend = m_pend | rise;
    end else begin
      m_pend = m_pend | rise;
      if (m_seq < D && i_branch_taken) m_seq = 0;
      else if (m_seq == D + I) m_seq = -1;
      else m_seq++;
    end
  endtask

  task automatic check_vec(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs == exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare mid-cycle, advance model at posedge
  task automatic tick(input string tag, input logic r, input logic irq,
                      input logic mrd, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic u1, input logic [2:0] rs2, input logic u2,
                      input logic br, input logic mb);
    @(negedge clk);
    rst = r; i_int = irq; i_ex_mem_read = mrd; i_ex_Rdst = rd;
    i_dec_Rsrc1 = rs1; i_dec_use1 = u1; i_dec_Rsrc2 = rs2; i_dec_use2 = u2;
    i_branch_taken = br; i_mem_busy = mb;
    #1;
    check_vec(tag, {o_pc_en, o_fd_en, o_da_en, o_am_en, o_mw_en, o_fd_bubble,
                    o_da_bubble, o_int_inject, o_int_step, o_int_vec, o_busy}, model_out());
    last_vec = o_int_vec;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input string tag, input logic irq);
    tick(tag, 1, irq, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Raise i_int once and report the cycle index at which o_int_vec shows up
  task automatic measure_vec(input int busy_from, input int busy_len, output int at);
    at = -1;
    idle("pre_edge", 0);
    for (int k = 0; k < 20; k++) begin
      tick("int_seq", 1, (k == 0), 0, 0, 0, 0, 0, 0, 0,
           (k >= busy_from && k < busy_from + busy_len));
      if (last_vec && at < 0) at = k;
    end
  endtask

  initial begin
    int at;
    int vec_seen;
    // reset state
    tick("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("reset1", 0, 1, 1, 3, 3, 1, 0, 0, 1, 0);
    idle("idle", 0);
    // load-use stall, then load has advanced
    tick("lu_stall", 1, 0, 1, 3, 3, 1, 0, 0, 0, 0);
    check_int("lu_pc_en", int'(o_pc_en | o_fd_en), 0);
    tick("lu_after", 1, 0, 0, 3, 3, 1, 0, 0, 0, 0);
    tick("lu_nouse", 1, 0, 1, 3, 3, 0, 5, 1, 0, 0);
    tick("lu_src2", 1, 0, 1, 5, 3, 0, 5, 1, 0, 0);
    tick("br_over_lu", 1, 0, 1, 3, 3, 1, 0, 0, 1, 0);
    tick("busy_over_br", 1, 0, 1, 3, 3, 1, 0, 0, 1, 1);
    // interrupt entry latency, plain and with a busy freeze on push step 0
    measure_vec(-1, 0, at);
    check_int("int_latency", at, INT_EN ? 1 + D + I : -1);
    measure_vec(1 + D, 4, at);
    check_int("int_busy_latency", at, INT_EN ? 1 + D + I + 4 : -1);
    // reset in the middle of push, i_int held high across release
    idle("pre_rst", 0);
    for (int k = 0; k < 1 + D; k++) idle("to_push", 1);
    tick("rst_push", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("rst_hold", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec_seen = 0;
    for (int k = 0; k < 12; k++) begin
      idle("post_rst", 1);
      vec_seen += int'(last_vec | o_busy);
    end
    check_int("no_int_after_rst", vec_seen, 0);
    measure_vec(-1, 0, at);
    check_int("int_after_rst", at, INT_EN ? 1 + D + I : -1);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      tick("random",
           logic'($urandom_range(0, 299) != 0),
           ($urandom_range(0, 14) == 0) ? ~i_int : i_int,
           logic'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
           3'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
           3'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 9) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
